// File: rtl/mem_access_stage_if.sv
// Handshake and bus bundle of the memory-access stage: EX issue, data-memory port, WB result.
// The stage binds to the slave modport; the surrounding pipeline/memory binds to master.
interface mem_access_stage_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
);
  localparam int unsigned STRB_W = XLEN / 8;

  logic              ex_valid;
  logic              ex_ready;
  logic [1:0]        ex_mem_op;
  logic [2:0]        ex_funct3;
  logic [XLEN-1:0]   ex_result;
  logic [XLEN-1:0]   ex_store_data;
  logic              ex_w_ena;
  logic [4:0]        ex_w_addr;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB_W-1:0] mem_wmask;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic              wb_valid;
  logic              wb_ready;
  logic [XLEN-1:0]   wb_data;
  logic              wb_w_ena;
  logic [4:0]        wb_w_addr;
  logic              wb_misalign;

  modport master (
    output ex_valid, ex_mem_op, ex_funct3, ex_result, ex_store_data, ex_w_ena, ex_w_addr,
    input  ex_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  wb_valid, wb_data, wb_w_ena, wb_w_addr, wb_misalign,
    output wb_ready
  );

  modport slave (
    input  ex_valid, ex_mem_op, ex_funct3, ex_result, ex_store_data, ex_w_ena, ex_w_addr,
    output ex_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output wb_valid, wb_data, wb_w_ena, wb_w_addr, wb_misalign,
    input  wb_ready
  );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V memory-access pipeline stage: lane-aligned loads/stores over req/gnt/rvalid, pass-through otherwise.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHK_EN.
module mem_access_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_stage_if.slave bus
);
  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e            state_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [STRB_W-1:0] mem_wmask_q;
  logic [2:0]        funct3_q;
  logic              w_ena_q;
  logic [4:0]        w_addr_q;
  logic              wb_valid_q, wb_w_ena_q, wb_misalign_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [4:0]        wb_w_addr_q;

  logic              ex_ready_c, accept_c, is_mem_c, misalign_c;
  logic [2:0]        funct3_c;
  logic [OFF_W-1:0]  off_c, rd_off_c;
  logic [7:0]        size_mask_c;
  logic [STRB_W-1:0] wmask_c;
  logic [XLEN-1:0]   wdata_c, rd_shift_c, rd_ext_c;

  assign ex_ready_c = (state_q == S_IDLE) && (!wb_valid_q || bus.wb_ready);
  assign accept_c   = bus.ex_valid && ex_ready_c;
  assign is_mem_c   = (bus.ex_mem_op == 2'b01) || (bus.ex_mem_op == 2'b10);
  assign off_c      = bus.ex_result[OFF_W-1:0];

  // Doubleword sizes collapse to word on a 32-bit datapath.
  always_comb begin
    funct3_c = bus.ex_funct3;
    if (XLEN == 32 && (bus.ex_funct3 == 3'b011 || bus.ex_funct3 == 3'b110)) funct3_c = 3'b010;
  end

  always_comb begin
    size_mask_c = 8'hFF;
    case (funct3_c[1:0])
      2'b00:   size_mask_c = 8'h01;
      2'b01:   size_mask_c = 8'h03;
      2'b10:   size_mask_c = 8'h0F;
      default: size_mask_c = 8'hFF;
    endcase
  end

  // Lanes shifted past the top of the word are simply dropped by truncation.
  assign wmask_c = STRB_W'(16'(size_mask_c) << off_c);
  assign wdata_c = bus.ex_store_data << {off_c, 3'b000};

`ifdef MEM_MISALIGN_CHK_EN
  logic [2:0] off3_c;
  assign off3_c = 3'(off_c);
  always_comb begin
    misalign_c = 1'b0;
    case (funct3_c[1:0])
      2'b01:   misalign_c = off3_c[0];
      2'b10:   misalign_c = (off3_c[1:0] != 2'b00);
      2'b11:   misalign_c = (off3_c != 3'b000);
      default: misalign_c = 1'b0;
    endcase
    misalign_c = misalign_c && is_mem_c;
  end
`else
  assign misalign_c = 1'b0;
`endif

  assign rd_off_c   = mem_addr_q[OFF_W-1:0];
  assign rd_shift_c = bus.mem_rdata >> {rd_off_c, 3'b000};

  always_comb begin
    rd_ext_c = rd_shift_c;
    case (funct3_q)
      3'b000:  rd_ext_c = XLEN'($signed(rd_shift_c[7:0]));
      3'b001:  rd_ext_c = XLEN'($signed(rd_shift_c[15:0]));
      3'b010:  rd_ext_c = XLEN'($signed(rd_shift_c[31:0]));
      3'b100:  rd_ext_c = XLEN'(rd_shift_c[7:0]);
      3'b101:  rd_ext_c = XLEN'(rd_shift_c[15:0]);
      3'b110:  rd_ext_c = XLEN'(rd_shift_c[31:0]);
      default: rd_ext_c = rd_shift_c;
    endcase
  end

  // Stage control and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wmask_q   <= '0;
      funct3_q      <= '0;
      w_ena_q       <= 1'b0;
      w_addr_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_w_ena_q    <= 1'b0;
      wb_w_addr_q   <= '0;
      wb_misalign_q <= 1'b0;
    end else begin
      if (wb_valid_q && bus.wb_ready) wb_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            if (is_mem_c && !misalign_c) begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.ex_mem_op[1];
              mem_addr_q  <= ADDR_W'(bus.ex_result);
              mem_wdata_q <= wdata_c;
              mem_wmask_q <= wmask_c;
              funct3_q    <= funct3_c;
              w_ena_q     <= bus.ex_w_ena;
              w_addr_q    <= bus.ex_w_addr;
            end else begin
              wb_valid_q    <= 1'b1;
              wb_data_q     <= bus.ex_result;
              wb_w_ena_q    <= bus.ex_w_ena && !misalign_c;
              wb_w_addr_q   <= bus.ex_w_addr;
              wb_misalign_q <= misalign_c;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              state_q       <= S_IDLE;
              wb_valid_q    <= 1'b1;
              wb_data_q     <= '0;
              wb_w_ena_q    <= 1'b0;
              wb_w_addr_q   <= w_addr_q;
              wb_misalign_q <= 1'b0;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            state_q       <= S_IDLE;
            wb_valid_q    <= 1'b1;
            wb_data_q     <= rd_ext_c;
            wb_w_ena_q    <= w_ena_q;
            wb_w_addr_q   <= w_addr_q;
            wb_misalign_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ex_ready    = ex_ready_c;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wmask   = mem_wmask_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_w_ena    = wb_w_ena_q;
  assign bus.wb_w_addr   = wb_w_addr_q;
  assign bus.wb_misalign = wb_misalign_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (XLEN=64); the misalign case follows MEM_MISALIGN_CHK_EN.
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_access_stage_if #(.XLEN(64), .ADDR_W(64)) bus ();
  mem_access_stage #(.XLEN(64), .ADDR_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [63:0] res,
                       input logic [63:0] sd, input logic wena, input logic [4:0] waddr);
    bus.ex_mem_op     = op;
    bus.ex_funct3     = f3;
    bus.ex_result     = res;
    bus.ex_store_data = sd;
    bus.ex_w_ena      = wena;
    bus.ex_w_addr     = waddr;
    bus.ex_valid      = 1'b1;
    tick();
    bus.ex_valid      = 1'b0;
  endtask

  // Load with immediate grant and rvalid one cycle later; wb_ready is held high.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] rdata, input logic [63:0] exp, input logic [4:0] waddr);
    issue(2'b01, f3, addr, 64'h0, 1'b1, waddr);
    chk({tag, ".req"}, 64'(bus.mem_req), 64'h1);
    chk({tag, ".we"}, 64'(bus.mem_we), 64'h0);
    chk({tag, ".addr"}, bus.mem_addr, addr);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    chk({tag, ".req_drop"}, 64'(bus.mem_req), 64'h0);
    chk({tag, ".wait_novalid"}, 64'(bus.wb_valid), 64'h0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    tick();
    bus.mem_rvalid = 1'b0;
    chk({tag, ".valid"}, 64'(bus.wb_valid), 64'h1);
    chk({tag, ".data"}, bus.wb_data, exp);
    chk({tag, ".waddr"}, 64'(bus.wb_w_addr), 64'(waddr));
    chk({tag, ".wena"}, 64'(bus.wb_w_ena), 64'h1);
    tick();
    chk({tag, ".drain"}, 64'(bus.wb_valid), 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_mem_op = 2'b00; bus.ex_funct3 = 3'b000;
    bus.ex_result = '0; bus.ex_store_data = '0; bus.ex_w_ena = 1'b0; bus.ex_w_addr = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.wb_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst.wb_valid", 64'(bus.wb_valid), 64'h0);
    chk("rst.mem_req", 64'(bus.mem_req), 64'h0);
    chk("rst.wb_data", bus.wb_data, 64'h0);
    chk("rst.wmask", 64'(bus.mem_wmask), 64'h0);
    chk("rst.misalign", 64'(bus.wb_misalign), 64'h0);
    chk("rst.ex_ready", 64'(bus.ex_ready), 64'h1);

    // Pass-through held while WB stalls.
    issue(2'b00, 3'b000, 64'h55, 64'h0, 1'b1, 5'd5);
    chk("pt.valid", 64'(bus.wb_valid), 64'h1);
    chk("pt.data", bus.wb_data, 64'h55);
    chk("pt.waddr", 64'(bus.wb_w_addr), 64'd5);
    chk("pt.ex_ready_stall", 64'(bus.ex_ready), 64'h0);
    tick(); tick();
    chk("pt.hold_valid", 64'(bus.wb_valid), 64'h1);
    chk("pt.hold_data", bus.wb_data, 64'h55);
    chk("pt.hold_ready", 64'(bus.ex_ready), 64'h0);
    bus.wb_ready = 1'b1;
    #1;
    chk("pt.ex_ready_release", 64'(bus.ex_ready), 64'h1);
    tick();
    chk("pt.cleared", 64'(bus.wb_valid), 64'h0);

    do_load("lb", 3'b000, 64'h1003, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80, 5'd7);
    do_load("lbu", 3'b100, 64'h1003, 64'h00000000_80000000, 64'h80, 5'd8);
    do_load("lw", 3'b010, 64'h1004, 64'h87654321_00000000, 64'hFFFFFFFF_87654321, 5'd9);
    do_load("lhu", 3'b101, 64'h1002, 64'h00000000_F00D0000, 64'hF00D, 5'd10);
    do_load("ld", 3'b011, 64'h1000, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 5'd11);

    // Store with grant held off for three cycles; request must stay stable.
    issue(2'b10, 3'b001, 64'h2006, 64'h1234, 1'b1, 5'd3);
    for (int i = 0; i < 4; i++) begin
      chk("sh.req", 64'(bus.mem_req), 64'h1);
      chk("sh.we", 64'(bus.mem_we), 64'h1);
      chk("sh.addr", bus.mem_addr, 64'h2006);
      chk("sh.wmask", 64'(bus.mem_wmask), 64'hC0);
      chk("sh.wdata", bus.mem_wdata, 64'h1234_0000_0000_0000);
      chk("sh.novalid", 64'(bus.wb_valid), 64'h0);
      if (i < 3) tick();
    end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    chk("sh.valid", 64'(bus.wb_valid), 64'h1);
    chk("sh.wena", 64'(bus.wb_w_ena), 64'h0);
    chk("sh.data", bus.wb_data, 64'h0);
    chk("sh.req_drop", 64'(bus.mem_req), 64'h0);
    tick();

    // Stray rvalid while idle is ignored.
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hDEAD;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("idle_rvalid", 64'(bus.wb_valid), 64'h0);

    // gnt and rvalid together in REQ: that rvalid is not the load data.
    issue(2'b01, 3'b011, 64'h3000, 64'h0, 1'b1, 5'd12);
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1111;
    tick();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    chk("gr.ignored", 64'(bus.wb_valid), 64'h0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h2222;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("gr.valid", 64'(bus.wb_valid), 64'h1);
    chk("gr.data", bus.wb_data, 64'h2222);
    tick();

    // Reset during WAIT aborts the load.
    issue(2'b01, 3'b010, 64'h4000, 64'h0, 1'b1, 5'd13);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw.req", 64'(bus.mem_req), 64'h0);
    chk("rw.valid", 64'(bus.wb_valid), 64'h0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hBAD;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("rw.stray", 64'(bus.wb_valid), 64'h0);
    issue(2'b00, 3'b000, 64'h77, 64'h0, 1'b1, 5'd14);
    chk("rw.after_valid", 64'(bus.wb_valid), 64'h1);
    chk("rw.after_data", bus.wb_data, 64'h77);
    tick();

    // Back-to-back pass-through at full throughput.
    bus.ex_mem_op = 2'b00; bus.ex_w_ena = 1'b1; bus.ex_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ex_result = 64'h100 + 64'(i);
      bus.ex_w_addr = 5'(i + 1);
      tick();
      chk("b2b.valid", 64'(bus.wb_valid), 64'h1);
      chk("b2b.data", bus.wb_data, 64'h100 + 64'(i));
      chk("b2b.ready", 64'(bus.ex_ready), 64'h1);
    end
    bus.ex_valid = 1'b0;
    tick();
    chk("b2b.drain", 64'(bus.wb_valid), 64'h0);

`ifdef MEM_MISALIGN_CHK_EN
    issue(2'b01, 3'b010, 64'h1002, 64'h0, 1'b1, 5'd15);
    chk("mis.req", 64'(bus.mem_req), 64'h0);
    chk("mis.valid", 64'(bus.wb_valid), 64'h1);
    chk("mis.flag", 64'(bus.wb_misalign), 64'h1);
    chk("mis.data", bus.wb_data, 64'h1002);
    chk("mis.wena", 64'(bus.wb_w_ena), 64'h0);
    tick();
    chk("mis.req_after", 64'(bus.mem_req), 64'h0);
`else
    issue(2'b01, 3'b010, 64'h1002, 64'h0, 1'b1, 5'd15);
    chk("mis.req", 64'(bus.mem_req), 64'h1);
    chk("mis.wmask", 64'(bus.mem_wmask), 64'h3C);
    chk("mis.flag", 64'(bus.wb_misalign), 64'h0);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h0000DEAD_BEEF0000;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("mis.data", bus.wb_data, 64'hFFFFFFFF_DEADBEEF);
    chk("mis.flag_wb", 64'(bus.wb_misalign), 64'h0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
